// File: rtl/depacketizer_pkg.sv
// Shared types and flit field-position helpers for the N-VC depacketizer.
// Positions and widths are derived from the flit/VC/address widths of the instantiating block.
package depacketizer_pkg;

   typedef enum logic [1:0] {IDLE, ASSEMBLE, DONE} vc_state_t;

   function automatic int valid_pos(input int wf);
      return wf - 1;
   endfunction

   function automatic int head_pos(input int wf);
      return wf - 2;
   endfunction

   function automatic int tail_pos(input int wf);
      return wf - 3;
   endfunction

   function automatic int vc_lsb(input int wf, input int vcw);
      return wf - 3 - vcw;
   endfunction

   function automatic int dest_lsb(input int wf, input int vcw, input int aw);
      return wf - 3 - vcw - aw;
   endfunction

   function automatic int head_w(input int wf, input int vcw, input int aw);
      return wf - 3 - vcw - aw;
   endfunction

   function automatic int body_w(input int wf, input int vcw);
      return wf - 3 - vcw;
   endfunction

   function automatic int data_idl_w(input int wf, input int nf, input int vcw, input int aw);
      return head_w(wf, vcw, aw) + (nf - 1) * body_w(wf, vcw);
   endfunction

endpackage

// File: rtl/depacketizer_n_vc_rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer, which moves to the slot
// after the winner whenever a grant is actually taken.
module rr_arbiter #(
   parameter int NUM_VC = 2,
   parameter int IDX_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_VC-1:0] req,
   input  logic              en,
   output logic [NUM_VC-1:0] gnt,
   output logic [IDX_W-1:0]  idx
);

   logic [IDX_W-1:0] ptr;
   logic             found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_VC; i++) begin
         if (!found && req[(int'(ptr) + i) % NUM_VC]) begin
            found = 1'b1;
            gnt[(int'(ptr) + i) % NUM_VC] = 1'b1;
            idx = IDX_W'((int'(ptr) + i) % NUM_VC);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (en && found) begin
         ptr <= IDX_W'((int'(idx) + 1) % NUM_VC);
      end
   end

endmodule

// File: rtl/depacketizer_n_vc.sv
// Flit-serial depacketizer: reassembles 1..NUM_FLITS-flit packets per virtual channel
// and forwards completed payloads round-robin through a registered valid/ready output.
module depacketizer_n_vc
   import depacketizer_pkg::*;
#(
   parameter int WIDTH_FLIT       = 36,
   parameter int NUM_FLITS        = 4,
   parameter int WIDTH_DATA       = 124,
   parameter int VC_ADDRESS_WIDTH = 1,
   parameter int ADDRESS_WIDTH    = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [WIDTH_FLIT-1:0]           flit_in,
   output logic [2**VC_ADDRESS_WIDTH-1:0]  ready_out,
   output logic [WIDTH_DATA-1:0]           data_out,
   output logic                            valid_out,
   output logic [VC_ADDRESS_WIDTH-1:0]     vc_out,
   input  logic                            ready_in,
   output logic                            error_out
);

   localparam int NUM_VC = 2**VC_ADDRESS_WIDTH;
   localparam int VCW    = VC_ADDRESS_WIDTH;
   localparam int HD     = head_w(WIDTH_FLIT, VCW, ADDRESS_WIDTH);
   localparam int BD     = body_w(WIDTH_FLIT, VCW);
   localparam int IDL    = data_idl_w(WIDTH_FLIT, NUM_FLITS, VCW, ADDRESS_WIDTH);
   localparam int CNT_W  = $clog2(NUM_FLITS + 1);

   vc_state_t        state  [NUM_VC];
   logic [IDL-1:0]   buffer [NUM_VC];
   logic [CNT_W-1:0] cnt    [NUM_VC];

   logic             flit_valid, flit_head, flit_tail, take;
   logic [VCW-1:0]   flit_vc;
   logic [HD-1:0]    head_pay;
   logic [BD-1:0]    body_pay;
   logic [NUM_VC-1:0] req, gnt;
   logic [VCW-1:0]   gnt_idx;
   logic             load_en, grant_en;

   assign flit_valid = (flit_in[valid_pos(WIDTH_FLIT)] == 1'b1);
   assign flit_head  = flit_in[head_pos(WIDTH_FLIT)];
   assign flit_tail  = flit_in[tail_pos(WIDTH_FLIT)];
   assign flit_vc    = flit_in[vc_lsb(WIDTH_FLIT, VCW) +: VCW];
   assign head_pay   = flit_in[HD-1:0];
   assign body_pay   = flit_in[BD-1:0];

   // Handshakes: a flit moves when flit_in valid and ready_out[vc]; an output beat
   // moves when valid_out and ready_in. ready_out depends on registered state only.
   always_comb begin
      for (int v = 0; v < NUM_VC; v++) begin
         ready_out[v] = (state[v] != DONE);
         req[v]       = (state[v] == DONE);
      end
   end

   assign take     = flit_valid && ready_out[flit_vc];
   assign load_en  = !valid_out || ready_in;
   assign grant_en = load_en && (|req);

   rr_arbiter #(.NUM_VC(NUM_VC), .IDX_W(VCW)) u_arb (
      .clk (clk),
      .rst (rst),
      .req (req),
      .en  (load_en),
      .gnt (gnt),
      .idx (gnt_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < NUM_VC; v++) begin
            state[v]  <= IDLE;
            buffer[v] <= '0;
            cnt[v]    <= '0;
         end
         valid_out <= 1'b0;
         data_out  <= '0;
         vc_out    <= '0;
         error_out <= 1'b0;
      end else begin
         error_out <= 1'b0;
         for (int v = 0; v < NUM_VC; v++) begin
            if (grant_en && gnt[v]) begin
               state[v] <= IDLE;
            end else if (take && flit_vc == VCW'(v)) begin
               if (flit_head) begin
                  // A head always (re)starts the packet; in ASSEMBLE the partial one is lost.
                  if (state[v] == ASSEMBLE) error_out <= 1'b1;
                  buffer[v] <= {head_pay, {(IDL-HD){1'b0}}};
                  cnt[v]    <= CNT_W'(1);
                  state[v]  <= flit_tail ? DONE : ASSEMBLE;
               end else if (state[v] == ASSEMBLE) begin
                  if (cnt[v] < CNT_W'(NUM_FLITS)) begin
                     for (int k = 1; k < NUM_FLITS; k++) begin
                        if (cnt[v] == CNT_W'(k)) buffer[v][IDL-1-HD-(k-1)*BD -: BD] <= body_pay;
                     end
                     cnt[v] <= cnt[v] + CNT_W'(1);
                  end else begin
                     error_out <= 1'b1;
                  end
                  if (flit_tail) state[v] <= DONE;
               end else begin
                  error_out <= 1'b1;
               end
            end
         end
         if (grant_en) begin
            valid_out <= 1'b1;
            data_out  <= buffer[gnt_idx][IDL-1 -: WIDTH_DATA];
            vc_out    <= gnt_idx;
         end else if (load_en) begin
            valid_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_depacketizer_n_vc.sv
// Directed bench for depacketizer_n_vc: packet-level reference model plus literal expectations.
module tb_depacketizer_n_vc;

   localparam int NVC = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [35:0]  flit_in;
   logic [1:0]   ready_out;
   logic [123:0] data_out;
   logic         valid_out;
   logic         vc_out;
   logic         ready_in;
   logic         error_out;

   depacketizer_n_vc #(
      .WIDTH_FLIT(36), .NUM_FLITS(4), .WIDTH_DATA(124), .VC_ADDRESS_WIDTH(1), .ADDRESS_WIDTH(4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flit_in   (flit_in),
      .ready_out (ready_out),
      .data_out  (data_out),
      .valid_out (valid_out),
      .vc_out    (vc_out),
      .ready_in  (ready_in),
      .error_out (error_out)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int err_seen = 0;
   int exp_err = 0;
   int base;

   logic [123:0] exp_q [NVC][$];
   logic [123:0] dlv_data[$];
   logic         dlv_vc[$];

   logic [123:0] m_buf [NVC];
   int           m_cnt [NVC];
   bit           m_act [NVC];

   bit           hold_pending = 1'b0;
   logic [123:0] prev_data;
   logic         prev_vc;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   function automatic logic [35:0] fh(input logic vc, input logic tail, input logic [27:0] p);
      return {1'b1, 1'b1, tail, vc, 4'h3, p};
   endfunction

   function automatic logic [35:0] fb(input logic vc, input logic tail, input logic [31:0] p);
      return {1'b1, 1'b0, tail, vc, p};
   endfunction

   // Packet-level model: payload placed by shifting into a 124-bit image.
   function automatic void mdl_take(input logic [35:0] f);
      logic         v;
      logic [123:0] word;
      v = f[32];
      if (f[34]) begin
         if (m_act[v]) exp_err++;
         m_buf[v] = {f[27:0], 96'h0};
         m_cnt[v] = 1;
         m_act[v] = 1'b1;
      end else if (!m_act[v]) begin
         exp_err++;
      end else if (m_cnt[v] < 4) begin
         word = {92'h0, f[31:0]};
         m_buf[v] = m_buf[v] | (word << (96 - 32 * m_cnt[v]));
         m_cnt[v]++;
      end else begin
         exp_err++;
      end
      if (f[33] && m_act[v]) begin
         exp_q[v].push_back(m_buf[v]);
         m_act[v] = 1'b0;
      end
   endfunction

   task automatic send(input logic [35:0] f);
      flit_in = f;
      if (ready_out[f[32]] === 1'b1) mdl_take(f);
      @(posedge clk);
      #1;
      flit_in = '0;
   endtask

   task automatic idle(input int n);
      flit_in = '0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         hold_pending = 1'b0;
      end else begin
         if (error_out === 1'b1) err_seen++;
         if (hold_pending) begin
            check("hold_valid", valid_out, 1);
            check("hold_data", data_out, prev_data);
            check("hold_vc", vc_out, prev_vc);
         end
         if (valid_out === 1'b1 && ready_in) begin
            dlv_data.push_back(data_out);
            dlv_vc.push_back(vc_out);
            tests++;
            if (exp_q[vc_out].size() == 0) begin
               fails++;
               $display("FAIL beat_unexpected: got vc %0d data %h, expected no beat", vc_out, data_out);
            end else begin
               tests--;
               check("beat_data", data_out, exp_q[vc_out].pop_front());
            end
         end
         hold_pending = (valid_out === 1'b1) && !ready_in;
         prev_data = data_out;
         prev_vc = vc_out;
      end
   end

   initial begin
      for (int v = 0; v < NVC; v++) begin
         m_buf[v] = '0;
         m_cnt[v] = 0;
         m_act[v] = 1'b0;
      end
      rst = 1'b1;
      flit_in = '0;
      ready_in = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_valid", valid_out, 0);
      check("rst_data", data_out, 0);
      check("rst_vc", vc_out, 0);
      check("rst_err", error_out, 0);
      check("rst_ready", ready_out, 2'b11);
      @(posedge clk);
      #1;

      // four-flit packet on VC0
      send(fh(1'b0, 1'b0, 28'hABCDEF1));
      send(fb(1'b0, 1'b0, 32'h11111111));
      send(fb(1'b0, 1'b0, 32'h22222222));
      send(fb(1'b0, 1'b1, 32'h33333333));
      @(negedge clk);
      check("c1_early", valid_out, 0);
      @(negedge clk);
      check("c1_valid", valid_out, 1);
      check("c1_data", data_out, {28'hABCDEF1, 32'h11111111, 32'h22222222, 32'h33333333});
      check("c1_vc", vc_out, 0);
      @(posedge clk);
      #1;

      // single-flit packet on VC1
      send(fh(1'b1, 1'b1, 28'h1234567));
      @(negedge clk);
      @(negedge clk);
      check("c2_valid", valid_out, 1);
      check("c2_data", data_out, {28'h1234567, 96'h0});
      check("c2_vc", vc_out, 1);
      @(posedge clk);
      #1;

      // both VCs done while output blocked, pointer at VC0
      dlv_data.delete();
      dlv_vc.delete();
      ready_in = 1'b0;
      send(fh(1'b1, 1'b1, 28'hAAAAAAA));
      idle(1);
      send(fh(1'b0, 1'b0, 28'h00000B0));
      send(fh(1'b1, 1'b0, 28'h00000C0));
      send(fb(1'b0, 1'b1, 32'h000000B1));
      send(fb(1'b1, 1'b1, 32'h000000C1));
      idle(2);
      ready_in = 1'b1;
      idle(6);
      check("c3_count", dlv_vc.size(), 3);
      check("c3_ord0", dlv_vc[0], 1);
      check("c3_ord1", dlv_vc[1], 0);
      check("c3_ord2", dlv_vc[2], 1);
      check("c3_data1", dlv_data[1], {28'h00000B0, 32'h000000B1, 64'h0});

      // both VCs done, pointer at VC1; output held for 10 cycles
      dlv_data.delete();
      dlv_vc.delete();
      ready_in = 1'b0;
      send(fh(1'b0, 1'b1, 28'hD0D0D0D));
      idle(1);
      send(fh(1'b0, 1'b0, 28'h00000E0));
      send(fh(1'b1, 1'b0, 28'h00000F0));
      send(fb(1'b0, 1'b1, 32'h000000E1));
      send(fb(1'b1, 1'b1, 32'h000000F1));
      idle(1);
      flit_in = fh(1'b0, 1'b1, 28'h6666666);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("c4_ready", ready_out, 2'b00);
         check("c4_valid", valid_out, 1);
         check("c4_data", data_out, {28'hD0D0D0D, 96'h0});
      end
      @(posedge clk);
      #1;
      flit_in = '0;
      ready_in = 1'b1;
      idle(6);
      check("c4_count", dlv_vc.size(), 3);
      check("c4_ord0", dlv_vc[0], 0);
      check("c4_ord1", dlv_vc[1], 1);
      check("c4_ord2", dlv_vc[2], 0);
      check("c4_data1", dlv_data[1], {28'h00000F0, 32'h000000F1, 64'h0});
      check("c4_data2", dlv_data[2], {28'h00000E0, 32'h000000E1, 64'h0});

      // protocol errors
      dlv_data.delete();
      dlv_vc.delete();
      base = err_seen;
      send(fb(1'b0, 1'b0, 32'h00000BAD));
      idle(1);
      send(fh(1'b0, 1'b0, 28'h1111111));
      send(fb(1'b0, 1'b0, 32'h0000000A));
      send(fh(1'b0, 1'b0, 28'h2222222));
      send(fb(1'b0, 1'b0, 32'h0000000B));
      send(fb(1'b0, 1'b1, 32'h0000000C));
      idle(2);
      send(fh(1'b0, 1'b0, 28'h3333333));
      send(fb(1'b0, 1'b0, 32'h1));
      send(fb(1'b0, 1'b0, 32'h2));
      send(fb(1'b0, 1'b0, 32'h3));
      send(fb(1'b0, 1'b0, 32'h4));
      send(fb(1'b0, 1'b1, 32'h5));
      idle(4);
      check("c5_errs", err_seen - base, 4);
      check("c5_count", dlv_data.size(), 2);
      check("c5_restart", dlv_data[0], {28'h2222222, 32'hB, 32'hC, 32'h0});
      check("c5_trunc", dlv_data[1], {28'h3333333, 32'h1, 32'h2, 32'h3});

      // reset in the middle of a VC0 packet
      dlv_data.delete();
      dlv_vc.delete();
      base = err_seen;
      send(fh(1'b0, 1'b0, 28'h7777777));
      send(fb(1'b0, 1'b0, 32'h00000007));
      rst = 1'b1;
      idle(2);
      for (int v = 0; v < NVC; v++) begin
         m_act[v] = 1'b0;
         m_cnt[v] = 0;
         m_buf[v] = '0;
         exp_q[v].delete();
      end
      rst = 1'b0;
      @(negedge clk);
      check("c6_ready", ready_out, 2'b11);
      check("c6_valid", valid_out, 0);
      check("c6_data", data_out, 0);
      check("c6_err", error_out, 0);
      @(posedge clk);
      #1;
      send(fh(1'b0, 1'b0, 28'h5555555));
      send(fb(1'b0, 1'b1, 32'h00000055));
      idle(4);
      check("c6_count", dlv_data.size(), 1);
      check("c6_data_out", dlv_data[0], {28'h5555555, 32'h00000055, 64'h0});
      check("c6_errs", err_seen - base, 0);

      check("final_pending", exp_q[0].size() + exp_q[1].size(), 0);
      check("final_errs", err_seen, exp_err);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
